// File: rtl/fpu_pkg.sv
// Shared FPU definitions: format geometry as functions of the float width,
// controller state encoding and canonical special-value encodings.
package fpu_pkg;

  typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, ROUND, DONE} fpu_state_e;

  typedef struct packed {
    logic nan;
    logic ovf;
    logic inexact;
    logic zero;
  } ftoi_flags_t;

  function automatic int exp_width(input int fw);
    return (fw == 64) ? 11 : 8;
  endfunction

  function automatic int frac_width(input int fw);
    return (fw == 64) ? 52 : 23;
  endfunction

  function automatic int exp_bias(input int fw);
    return (1 << (exp_width(fw) - 1)) - 1;
  endfunction

  function automatic int exp_max(input int fw);
    return (1 << exp_width(fw)) - 1;
  endfunction

  localparam logic [31:0] F32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] F32_PINF = 32'h7F80_0000;
  localparam logic [63:0] F64_QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] F64_PINF = 64'h7FF0_0000_0000_0000;

endpackage

// File: rtl/float_to_int_if.sv
// Start/done handshake and result bus of the float-to-int converter.
interface float_to_int_if import fpu_pkg::*; #(
  parameter int FLOAT_WIDTH = 64,
  parameter int INT_WIDTH   = 64
);
  logic                   start;
  logic [FLOAT_WIDTH-1:0] op;
  logic [INT_WIDTH-1:0]   out_reg;
  logic                   nan_reg;
  logic                   overflow_reg;
  logic                   inexact_reg;
  logic                   zero_reg;
  logic                   done_reg;
  logic                   busy;

  modport master (output start, op,
                  input  out_reg, nan_reg, overflow_reg, inexact_reg, zero_reg, done_reg, busy);
  modport slave  (input  start, op,
                  output out_reg, nan_reg, overflow_reg, inexact_reg, zero_reg, done_reg, busy);
endinterface

// File: rtl/float_unpack.sv
// Combinational IEEE-754 field split and classification; shared with the adder.
module float_unpack import fpu_pkg::*; #(
  parameter  int FLOAT_WIDTH = 64,
  localparam int EW  = exp_width(FLOAT_WIDTH),
  localparam int FRW = frac_width(FLOAT_WIDTH)
) (
  input  logic [FLOAT_WIDTH-1:0] op,
  output logic                   sign,
  output logic [EW-1:0]          exp,
  output logic [FRW-1:0]         frac,
  output logic                   is_zero,
  output logic                   is_denorm,
  output logic                   is_inf,
  output logic                   is_nan
);
  localparam logic [EW-1:0] EMAX = EW'(exp_max(FLOAT_WIDTH));

  assign sign      = op[FLOAT_WIDTH-1];
  assign exp       = op[FLOAT_WIDTH-2 -: EW];
  assign frac      = op[FRW-1:0];
  assign is_zero   = (exp == '0) && (frac == '0);
  assign is_denorm = (exp == '0) && (frac != '0);
  assign is_inf    = (exp == EMAX) && (frac == '0);
  assign is_nan    = (exp == EMAX) && (frac != '0);
endmodule

// File: rtl/float_to_int.sv
// Multi-cycle float -> integer converter, round-to-nearest-even, bit-serial right shift.
// Define FTOI_SATURATE_EN to saturate overflow to INT_MIN/INT_MAX and map NaN to 0.
module float_to_int import fpu_pkg::*; #(
  parameter int FLOAT_WIDTH = 64,
  parameter int INT_WIDTH   = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  float_to_int_if.slave  io
);
  localparam int EW   = exp_width(FLOAT_WIDTH);
  localparam int FRW  = frac_width(FLOAT_WIDTH);
  localparam int BIAS = exp_bias(FLOAT_WIDTH);
  localparam int IW   = INT_WIDTH;
  // Magnitude keeps one bit above both the mantissa and the integer so the rounding carry survives.
  localparam int MW   = ((FRW + 1 > IW) ? FRW + 1 : IW) + 1;
  localparam int CW   = $clog2(FRW + 2);

  localparam logic [IW-1:0] INT_MIN = {1'b1, {(IW-1){1'b0}}};
  localparam logic [IW-1:0] INT_MAX = ~INT_MIN;
  localparam logic [MW-1:0] POS_LIM = MW'(INT_MAX);
  localparam logic [MW-1:0] NEG_LIM = MW'(INT_MIN);
`ifdef FTOI_SATURATE_EN
  localparam logic [IW-1:0] OVF_POS = INT_MAX;
  localparam logic [IW-1:0] NAN_INT = '0;
`else
  localparam logic [IW-1:0] OVF_POS = INT_MIN;
  localparam logic [IW-1:0] NAN_INT = INT_MIN;
`endif
  localparam logic [IW-1:0] OVF_NEG = INT_MIN;

  fpu_state_e             state, state_d;
  logic [FLOAT_WIDTH-1:0] op_q;
  logic [MW-1:0]          m_q, m_d, mag;
  logic                   guard_q, guard_d, sticky_q, sticky_d, inc, load;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          res, lsh;
  ftoi_flags_t            flg;
  int                     e;

  logic           u_sign, u_zero, u_denorm, u_inf, u_nan;
  logic [EW-1:0]  u_exp;
  logic [FRW-1:0] u_frac;

  float_unpack #(.FLOAT_WIDTH(FLOAT_WIDTH)) u_unpack (
    .op(op_q), .sign(u_sign), .exp(u_exp), .frac(u_frac),
    .is_zero(u_zero), .is_denorm(u_denorm), .is_inf(u_inf), .is_nan(u_nan)
  );

  assign e       = int'(u_exp) - BIAS;
  assign io.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_d;

  always_comb begin
    state_d  = state;
    load     = 1'b0;
    res      = '0;
    flg      = '0;
    m_d      = m_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    mag      = '0;
    lsh      = '0;
    inc      = 1'b0;
    case (state)
      IDLE: if (io.start) state_d = UNPACK;
      UNPACK: begin
        m_d      = MW'({1'b1, u_frac});
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        cnt_d    = CW'(FRW - e);
        state_d  = DONE;
        load     = 1'b1;
        if (u_nan) begin
          flg.nan = 1'b1;
          res     = NAN_INT;
        end else if (u_inf) begin
          flg.ovf = 1'b1;
          res     = u_sign ? OVF_NEG : OVF_POS;
        end else if (u_zero || u_denorm || e < -1) begin
          flg.zero    = 1'b1;
          flg.inexact = !u_zero;
        end else if (e >= IW - 1) begin
          // -2^(IW-1) is the one value at this exponent that still fits.
          if (u_sign && e == IW - 1 && u_frac == '0) res = INT_MIN;
          else begin
            flg.ovf = 1'b1;
            res     = u_sign ? OVF_NEG : OVF_POS;
          end
        end else if (e >= FRW) begin
          lsh = IW'(m_d) << (e - FRW);
          res = u_sign ? -lsh : lsh;
        end else begin
          state_d = SHIFT;
          load    = 1'b0;
        end
      end
      SHIFT: begin
        m_d      = m_q >> 1;
        guard_d  = m_q[0];
        sticky_d = sticky_q | guard_q;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ROUND;
      end
      ROUND: begin
        inc         = guard_q & (sticky_q | m_q[0]);
        mag         = m_q + MW'(inc);
        flg.inexact = guard_q | sticky_q;
        load        = 1'b1;
        state_d     = DONE;
        if ((!u_sign && mag > POS_LIM) || (u_sign && mag > NEG_LIM)) begin
          flg.ovf = 1'b1;
          res     = u_sign ? OVF_NEG : OVF_POS;
        end else begin
          res      = u_sign ? -mag[IW-1:0] : mag[IW-1:0];
          flg.zero = (mag == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q            <= '0;
      m_q             <= '0;
      guard_q         <= 1'b0;
      sticky_q        <= 1'b0;
      cnt_q           <= '0;
      io.out_reg      <= '0;
      io.nan_reg      <= 1'b0;
      io.overflow_reg <= 1'b0;
      io.inexact_reg  <= 1'b0;
      io.zero_reg     <= 1'b0;
      io.done_reg     <= 1'b0;
    end else begin
      if (state == IDLE && io.start) op_q <= io.op;
      m_q         <= m_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      io.done_reg <= load;
      if (load) begin
        io.out_reg      <= res;
        io.nan_reg      <= flg.nan;
        io.overflow_reg <= flg.ovf;
        io.inexact_reg  <= flg.inexact;
        io.zero_reg     <= flg.zero;
      end
    end
  end
endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int (32-bit float -> 32-bit int): directed cases,
// handshake and mid-operation reset, then random operands against an arithmetic model.
module tb_float_to_int;
  localparam int FW = 32;
  localparam int IW = 32;
`ifdef FTOI_SATURATE_EN
  localparam logic [31:0] OVP = 32'h7FFF_FFFF;
  localparam logic [31:0] NANV = 32'h0;
`else
  localparam logic [31:0] OVP = 32'h8000_0000;
  localparam logic [31:0] NANV = 32'h8000_0000;
`endif

  typedef struct {
    logic [31:0] out;
    logic        nan, ovf, inex, zero;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  float_to_int_if #(.FLOAT_WIDTH(FW), .INT_WIDTH(IW)) bus ();
  float_to_int #(.FLOAT_WIDTH(FW), .INT_WIDTH(IW)) dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
      $error("check %s", tag);
    end
  endtask

  // Exact rational value m * 2^(e-23), rounded to nearest even with integer arithmetic.
  function automatic exp_t model(input logic [31:0] f);
    exp_t   r;
    logic   s;
    int     ex, e, sh;
    longint m, q, rem, half, mag;
    s = f[31];
    ex = int'(f[30:23]);
    e = ex - 127;
    m = longint'({1'b1, f[22:0]});
    r.out = 0; r.nan = 0; r.ovf = 0; r.inex = 0; r.zero = 0; r.lat = 2;
    if (ex == 255) begin
      if (f[22:0] != 0) begin r.nan = 1; r.out = NANV; end
      else begin r.ovf = 1; r.out = s ? 32'h8000_0000 : OVP; end
    end else if (e < -1) begin
      r.zero = 1;
      r.inex = (f[30:0] != 0);
    end else if (e >= 31) begin
      if (s && e == 31 && f[22:0] == 0) r.out = 32'h8000_0000;
      else begin r.ovf = 1; r.out = s ? 32'h8000_0000 : OVP; end
    end else if (e >= 23) begin
      mag = m << (e - 23);
      r.out = s ? 32'(-mag) : 32'(mag);
    end else begin
      sh = 23 - e;
      q = m >> sh;
      rem = m - (q << sh);
      half = longint'(1) << (sh - 1);
      mag = q + ((rem > half || (rem == half && q[0])) ? 1 : 0);
      r.inex = (rem != 0);
      r.lat = sh + 3;
      if ((!s && mag > 64'sh7FFF_FFFF) || (s && mag > 64'sh8000_0000)) begin
        r.ovf = 1; r.out = s ? 32'h8000_0000 : OVP;
      end else begin
        r.out = s ? 32'(-mag) : 32'(mag);
        r.zero = (mag == 0);
      end
    end
    return r;
  endfunction

  task automatic launch(input logic [31:0] f);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 100) begin @(negedge clk); k++; end
    chk("idle_before_start", 64'(bus.busy), 64'd0);
    bus.op = f;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(inout int lat);
    while (!bus.done_reg && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("done_seen", 64'(bus.done_reg), 64'd1);
  endtask

  task automatic finish_check(input string tag, input exp_t x, input int lat);
    chk({tag, ".out"},  64'(bus.out_reg),      64'(x.out));
    chk({tag, ".nan"},  64'(bus.nan_reg),      64'(x.nan));
    chk({tag, ".ovf"},  64'(bus.overflow_reg), 64'(x.ovf));
    chk({tag, ".inex"}, 64'(bus.inexact_reg),  64'(x.inex));
    chk({tag, ".zero"}, 64'(bus.zero_reg),     64'(x.zero));
    chk({tag, ".lat"},  64'(lat),              64'(x.lat));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 64'(bus.done_reg), 64'd0);
    chk({tag, ".hold"},  64'(bus.out_reg),  64'(x.out));
  endtask

  task automatic run(input string tag, input logic [31:0] f, input exp_t x);
    int lat;
    launch(f);
    lat = 1;
    wait_done(lat);
    finish_check(tag, x, lat);
  endtask

  function automatic exp_t mk(input logic [31:0] o, input logic n, input logic v,
                              input logic i, input logic z, input int l);
    exp_t r;
    r.out = o; r.nan = n; r.ovf = v; r.inex = i; r.zero = z; r.lat = l;
    return r;
  endfunction

  initial begin
    exp_t        x;
    logic [31:0] r;
    int          lat;
    bus.start = 1'b0;
    bus.op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out",  64'(bus.out_reg), 64'd0);
    chk("rst.flags", 64'({bus.nan_reg, bus.overflow_reg, bus.inexact_reg, bus.zero_reg}), 64'd0);
    chk("rst.done", 64'(bus.done_reg), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run("pi",      32'h40490FDB, mk(32'd3,          0, 0, 1, 0, 25));
    run("p2_5",    32'h40200000, mk(32'd2,          0, 0, 1, 0, 25));
    run("m2_5",    32'hC0200000, mk(32'hFFFF_FFFE,  0, 0, 1, 0, 25));
    run("p1_5",    32'h3FC00000, mk(32'd2,          0, 0, 1, 0, 26));
    run("p0_5",    32'h3F000000, mk(32'd0,          0, 0, 1, 1, 27));
    run("p0_75",   32'h3F400000, mk(32'd1,          0, 0, 1, 0, 27));
    run("intmin",  32'hCF000000, mk(32'h8000_0000,  0, 0, 0, 0, 2));
    run("p2_31",   32'h4F000000, mk(OVP,            0, 1, 0, 0, 2));
    run("maxexact",32'h4EFFFFFF, mk(32'h7FFF_FF80,  0, 0, 0, 0, 2));
    run("qnan",    32'h7FC00000, mk(NANV,           1, 0, 0, 0, 2));
    run("ninf",    32'hFF800000, mk(32'h8000_0000,  0, 1, 0, 0, 2));
    run("denorm",  32'h00000001, mk(32'd0,          0, 0, 1, 1, 2));

    // Second start while busy must be dropped; the first operand's result arrives.
    launch(32'h40490FDB);
    lat = 1;
    repeat (2) begin @(posedge clk); #1; lat++; end
    bus.op = 32'h41200000;
    bus.start = 1'b1;
    @(posedge clk); #1; lat++;
    bus.start = 1'b0;
    wait_done(lat);
    finish_check("busy_start", mk(32'd3, 0, 0, 1, 0, 25), lat);
    run("after_done", 32'h41200000, mk(32'd10, 0, 0, 0, 0, 23));

    // Reset in the middle of the shift phase.
    launch(32'h40490FDB);
    repeat (4) @(posedge clk);
    #1;
    chk("mid.busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.out",  64'(bus.out_reg), 64'd0);
    chk("mid.flags", 64'({bus.nan_reg, bus.overflow_reg, bus.inexact_reg, bus.zero_reg}), 64'd0);
    chk("mid.busy", 64'(bus.busy), 64'd0);
    lat = 0;
    repeat (30) begin @(posedge clk); #1; if (bus.done_reg) lat++; if (lat == 0) rst_n = 1'b1; end
    chk("mid.no_done", 64'(lat), 64'd0);
    chk("mid.idle", 64'(bus.busy), 64'd0);
    run("p123", 32'h42F60000, mk(32'd123, 0, 0, 0, 0, 20));

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if (i % 4 != 0) r[30:23] = 8'($urandom_range(100, 160));
      x = model(r);
      run("rand", r, x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
